// File: rtl/sobel_pkg.sv
// sobel_pkg: shared types and constants for the Sobel stream controller.
//   PIX_W_DEFAULT : default pixel width
//   win_t         : packed 3x3 pixel window at the default width
//   state_t       : scheduler states IDLE / FILL / RUN / FLUSH
//   WIN_*         : tap index of each neighbour inside the flattened window;
//                   tap i occupies bits [i*PIX_W +: PIX_W], row-major,
//                   top-left in the LSBs
package sobel_pkg;

  localparam int PIX_W_DEFAULT = 8;

  typedef logic [2:0][2:0][PIX_W_DEFAULT-1:0] win_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam int WIN_TL   = 0;
  localparam int WIN_TC   = 1;
  localparam int WIN_TR   = 2;
  localparam int WIN_ML   = 3;
  localparam int WIN_MC   = 4;
  localparam int WIN_MR   = 5;
  localparam int WIN_BL   = 6;
  localparam int WIN_BC   = 7;
  localparam int WIN_BR   = 8;
  localparam int WIN_TAPS = 9;

endpackage

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: one image line of delay, COLS entries deep, as a circular
// buffer. On each advance the entry under the pointer is presented on rd_o
// (the pixel written COLS advances earlier) and overwritten with wr_i.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (pointer only, contents kept)
//   adv_i : advance one pixel (read old entry, write new one)
//   wr_i  : pixel entering the line
//   rd_o  : pixel leaving the line (same column, previous row)
module sobel_line_buf #(
  parameter int COLS  = 1280,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv_i,
  input  logic [PIX_W-1:0] wr_i,
  output logic [PIX_W-1:0] rd_o
);

  localparam int AW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(COLS - 1);

  logic [PIX_W-1:0] mem_q [COLS];
  logic [AW-1:0]    ptr_q;
  logic [AW-1:0]    ptr_d;

  assign rd_o  = mem_q[ptr_q];
  assign ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + AW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (adv_i) begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv_i) begin
      mem_q[ptr_q] <= wr_i;
    end
  end

endmodule

// File: rtl/sobel_stream_ctrl.sv
// sobel_stream_ctrl: streaming scheduler for a 3x3 Sobel datapath. Takes one
// raster-order frame at a time, keeps two chained line buffers plus a column
// shift register, and issues one 3x3 window per downstream handshake. Border
// windows are flagged and zeroed; the last row is flushed without input.
// Optional feature macro: SOBEL_ERR_CHECK_EN (adds sticky err_sof output).
// Ports:
//   clk, rst         : clock and synchronous active-high reset
//   in_valid/in_ready: input pixel handshake
//   in_data, in_sof  : pixel and first-pixel marker (informational)
//   win_valid/win_ready : window handshake (single-entry output register)
//   win              : 3x3 window, top-left in LSBs, row-major
//   win_border       : centre lies on the frame border (win forced to 0)
//   win_sof, win_eof : centre is the first / last pixel of the frame
//   frame_busy       : first pixel accepted .. last window accepted
//   err_sof          : (SOBEL_ERR_CHECK_EN only) sticky sof/index mismatch
module sobel_stream_ctrl
  import sobel_pkg::*;
#(
  parameter int ROWS  = 953,
  parameter int COLS  = 1280,
  parameter int PIX_W = PIX_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PIX_W-1:0]          in_data,
  input  logic                      in_sof,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [WIN_TAPS*PIX_W-1:0] win,
  output logic                      win_border,
  output logic                      win_sof,
  output logic                      win_eof,
  output logic                      frame_busy
`ifdef SOBEL_ERR_CHECK_EN
  ,
  output logic                      err_sof
`endif
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  state_t                      state_q;
  logic [RW-1:0]               in_row_q, in_row_d;
  logic [CW-1:0]               in_col_q, in_col_d;
  logic [RW-1:0]               gen_row_q, gen_row_d;
  logic [CW-1:0]               gen_col_q, gen_col_d;
  logic                        win_valid_q;
  logic [WIN_TAPS*PIX_W-1:0]   win_q;
  logic                        border_q, sof_q, eof_q, busy_q;

  logic                        rdy;
  logic                        acc_in, acc_win;
  logic                        load_run, load_flush, load;
  logic                        in_last, gen_border, gen_first, gen_last;
  logic [PIX_W-1:0]            lb0_rd, lb1_rd;
  logic [PIX_W-1:0]            top_q [2];
  logic [PIX_W-1:0]            mid_q [2];
  logic [PIX_W-1:0]            bot_q [2];
  logic [WIN_TAPS*PIX_W-1:0]   win_pix;

  // lb1 delays the stream by one row, lb0 by two: together with the incoming
  // pixel they give the three rows of the column at the current input index.
  sobel_line_buf #(.COLS(COLS), .PIX_W(PIX_W)) u_lb1 (
    .clk   (clk),
    .rst   (rst),
    .adv_i (acc_in),
    .wr_i  (in_data),
    .rd_o  (lb1_rd)
  );

  sobel_line_buf #(.COLS(COLS), .PIX_W(PIX_W)) u_lb0 (
    .clk   (clk),
    .rst   (rst),
    .adv_i (acc_in),
    .wr_i  (lb1_rd),
    .rd_o  (lb0_rd)
  );

  always_comb begin
    rdy = 1'b0;
    case (state_q)
      IDLE, FILL: rdy = 1'b1;
      RUN:        rdy = !win_valid_q || win_ready;
      FLUSH:      rdy = 1'b0;
      default:    rdy = 1'b0;
    endcase
  end

  assign in_ready = rdy && !rst;
  assign acc_in   = in_valid && in_ready;
  assign acc_win  = win_valid_q && win_ready;

  assign in_last    = (in_row_q == ROW_LAST) && (in_col_q == COL_LAST);
  assign gen_border = (gen_row_q == '0) || (gen_row_q == ROW_LAST) ||
                      (gen_col_q == '0) || (gen_col_q == COL_LAST);
  assign gen_first  = (gen_row_q == '0) && (gen_col_q == '0);
  assign gen_last   = (gen_row_q == ROW_LAST) && (gen_col_q == COL_LAST);

  // In RUN every accepted pixel completes the window whose bottom-right
  // neighbour it is; in FLUSH the remaining (all border) windows are issued
  // as the previous one drains, stopping once the eof window is loaded.
  assign load_run   = (state_q == RUN) && acc_in;
  assign load_flush = (state_q == FLUSH) && acc_win && !eof_q;
  assign load       = load_run || load_flush;

  always_comb begin
    in_col_d = in_col_q + CW'(1);
    in_row_d = in_row_q;
    if (in_col_q == COL_LAST) begin
      in_col_d = '0;
      in_row_d = (in_row_q == ROW_LAST) ? '0 : in_row_q + RW'(1);
    end
  end

  always_comb begin
    gen_col_d = gen_col_q + CW'(1);
    gen_row_d = gen_row_q;
    if (gen_col_q == COL_LAST) begin
      gen_col_d = '0;
      gen_row_d = (gen_row_q == ROW_LAST) ? '0 : gen_row_q + RW'(1);
    end
  end

  // Index 0 of each shift register is the older column (c-1), index 1 the
  // centre column (c); the incoming column is the right-hand one.
  always_comb begin
    win_pix = '0;
    win_pix[WIN_TL*PIX_W +: PIX_W] = top_q[0];
    win_pix[WIN_TC*PIX_W +: PIX_W] = top_q[1];
    win_pix[WIN_TR*PIX_W +: PIX_W] = lb0_rd;
    win_pix[WIN_ML*PIX_W +: PIX_W] = mid_q[0];
    win_pix[WIN_MC*PIX_W +: PIX_W] = mid_q[1];
    win_pix[WIN_MR*PIX_W +: PIX_W] = lb1_rd;
    win_pix[WIN_BL*PIX_W +: PIX_W] = bot_q[0];
    win_pix[WIN_BC*PIX_W +: PIX_W] = bot_q[1];
    win_pix[WIN_BR*PIX_W +: PIX_W] = in_data;
  end

  always_ff @(posedge clk) begin
    if (acc_in) begin
      top_q[0] <= top_q[1];
      top_q[1] <= lb0_rd;
      mid_q[0] <= mid_q[1];
      mid_q[1] <= lb1_rd;
      bot_q[0] <= bot_q[1];
      bot_q[1] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_row_q    <= '0;
      in_col_q    <= '0;
      gen_row_q   <= '0;
      gen_col_q   <= '0;
      win_valid_q <= 1'b0;
      win_q       <= '0;
      border_q    <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (acc_in) begin
        in_row_q <= in_row_d;
        in_col_q <= in_col_d;
      end

      if (load) begin
        win_valid_q <= 1'b1;
        // Border neighbourhoods reach outside the frame; the line buffers
        // hold stale or wrapped data there, so the window is zeroed.
        win_q       <= (load_run && !gen_border) ? win_pix : '0;
        border_q    <= gen_border;
        sof_q       <= gen_first;
        eof_q       <= gen_last;
        gen_row_q   <= gen_row_d;
        gen_col_q   <= gen_col_d;
      end else if (acc_win) begin
        win_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (acc_in) begin
            state_q <= FILL;
            busy_q  <= 1'b1;
          end
        end
        FILL: begin
          // Index COLS is row 1, col 0: the next pixel completes window 0.
          if (acc_in && (in_row_q == RW'(1)) && (in_col_q == '0)) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (acc_in && in_last) begin
            state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (acc_win && eof_q) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            in_row_q  <= '0;
            in_col_q  <= '0;
            gen_row_q <= '0;
            gen_col_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SOBEL_ERR_CHECK_EN
  logic err_sof_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sof_q <= 1'b0;
    end else if (acc_in && (in_sof != ((in_row_q == '0) && (in_col_q == '0)))) begin
      err_sof_q <= 1'b1;
    end
  end

  assign err_sof = err_sof_q;
`else
  logic unused_in_sof;
  assign unused_in_sof = in_sof;
`endif

  assign win_valid  = win_valid_q;
  assign win        = win_q;
  assign win_border = border_q;
  assign win_sof    = sof_q;
  assign win_eof    = eof_q;
  assign frame_busy = busy_q;

endmodule
